// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer: entry layout, completion port, pointer width.
package C;

  localparam int NR_ROB_ENTRIES = 32;
  localparam int NR_COMPL_PORTS = 3;

  typedef logic [7:0] id_t;

  typedef logic [$clog2(NR_ROB_ENTRIES):0] rob_ptr_t;

  typedef struct packed {
    id_t         id;
    logic [31:0] pc;
    logic [6:0]  prd;
    logic [4:0]  ard;
    logic        needprf2arf;
    logic        completed;
  } rob_entry_t;

  typedef struct packed {
    id_t  id;
    logic valid;
  } completion_port_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: program-order dispatch, any-order completion,
// one in-order commit per cycle from the head, single-cycle flush.
module reorder_buffer
  import C::*;
#(
  parameter int NR_ENTRIES = NR_ROB_ENTRIES,
  parameter int NR_CPORTS  = NR_COMPL_PORTS
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          dispatch_valid_i,
  output logic                          dispatch_ready_o,
  input  rob_entry_t                    dispatch_entry_i,
  input  completion_port_t              compl_i [NR_CPORTS],
  output logic                          commit_valid_o,
  input  logic                          commit_ready_i,
  output rob_entry_t                    commit_entry_o,
  input  logic                          flush_i,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(NR_ENTRIES):0]   count_o
);

  localparam int AW = $clog2(NR_ENTRIES);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  rob_entry_t              r_entries [NR_ENTRIES];
  logic [NR_ENTRIES-1:0]   r_valid;
  logic [NR_ENTRIES-1:0]   r_completed;
  logic [PW-1:0]           r_head;
  logic [PW-1:0]           r_tail;
  logic [PW-1:0]           r_count;

  logic [AW-1:0]           w_head_idx;
  logic [AW-1:0]           w_tail_idx;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_disp_fire;
  logic                    w_commit_fire;
  logic [NR_ENTRIES-1:0]   w_hit;
  logic [PW-1:0]           w_count_next;
  rob_entry_t              w_disp_entry;
  rob_entry_t              w_head_entry;

  assign w_head_idx = r_head[AW-1:0];
  assign w_tail_idx = r_tail[AW-1:0];

  // Wrap bit distinguishes full from empty when the index bits coincide.
  assign w_empty = (r_head == r_tail);
  assign w_full  = (w_head_idx == w_tail_idx) && (r_head[AW] != r_tail[AW]);

  assign dispatch_ready_o = !w_full;
  assign full_o           = w_full;
  assign empty_o          = w_empty;
  assign count_o          = r_count;

  assign w_disp_fire    = dispatch_valid_i && dispatch_ready_o && !flush_i;
  assign commit_valid_o = !w_empty && r_valid[w_head_idx] && r_completed[w_head_idx] && !flush_i;
  assign w_commit_fire  = commit_valid_o && commit_ready_i;

  assign w_count_next = r_count + PW'(w_disp_fire) - PW'(w_commit_fire);

  always_comb begin
    w_disp_entry           = dispatch_entry_i;
    w_disp_entry.completed = 1'b0;
  end

  always_comb begin
    w_head_entry           = r_entries[w_head_idx];
    commit_entry_o         = w_head_entry;
    commit_entry_o.completed = 1'b1;
  end

  always_comb begin
    w_hit = '0;
    for (int e = 0; e < NR_ENTRIES; e++) begin
      for (int p = 0; p < NR_CPORTS; p++) begin
        if (compl_i[p].valid && r_valid[e] && (r_entries[e].id == compl_i[p].id)) begin
          w_hit[e] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_valid     <= '0;
      r_completed <= '0;
    end else if (flush_i) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_valid     <= '0;
      r_completed <= '0;
    end else begin
      r_completed <= r_completed | w_hit;
      if (w_disp_fire) begin
        r_valid[w_tail_idx]     <= 1'b1;
        r_completed[w_tail_idx] <= 1'b0;
        r_tail                  <= r_tail + PTR_ONE;
      end
      // Head and tail slots never coincide when both fire (not full, not empty).
      if (w_commit_fire) begin
        r_valid[w_head_idx]     <= 1'b0;
        r_completed[w_head_idx] <= 1'b0;
        r_head                  <= r_head + PTR_ONE;
      end
      r_count <= w_count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_disp_fire) begin
      r_entries[w_tail_idx] <= w_disp_entry;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer.
module tb_reorder_buffer;
  import C::*;

  logic              clk;
  logic              rstn;
  logic              dispatch_valid_i;
  logic              dispatch_ready_o;
  rob_entry_t        dispatch_entry_i;
  completion_port_t  compl_i [NR_COMPL_PORTS];
  logic              commit_valid_o;
  logic              commit_ready_i;
  rob_entry_t        commit_entry_o;
  logic              flush_i;
  logic              full_o;
  logic              empty_o;
  logic [5:0]        count_o;

  int n_tests;
  int n_fail;

  reorder_buffer dut (
    .clk              (clk),
    .rstn             (rstn),
    .dispatch_valid_i (dispatch_valid_i),
    .dispatch_ready_o (dispatch_ready_o),
    .dispatch_entry_i (dispatch_entry_i),
    .compl_i          (compl_i),
    .commit_valid_o   (commit_valid_o),
    .commit_ready_i   (commit_ready_i),
    .commit_entry_o   (commit_entry_o),
    .flush_i          (flush_i),
    .full_o           (full_o),
    .empty_o          (empty_o),
    .count_o          (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Incoming completed is set to 1 on purpose: the ROB must ignore it.
  function automatic rob_entry_t mk(input id_t id);
    rob_entry_t e;
    e.id          = id;
    e.pc          = 32'h0000_1000 + {22'd0, id, 2'b00};
    e.prd         = id[6:0];
    e.ard         = id[4:0];
    e.needprf2arf = id[0];
    e.completed   = 1'b1;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dispatch_valid_i = 1'b0;
    dispatch_entry_i = '0;
    commit_ready_i   = 1'b0;
    flush_i          = 1'b0;
    for (int p = 0; p < NR_COMPL_PORTS; p++) compl_i[p] = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    tick();
  endtask

  task automatic disp(input id_t id);
    dispatch_valid_i = 1'b1;
    dispatch_entry_i = mk(id);
    tick();
    dispatch_valid_i = 1'b0;
  endtask

  task automatic compl1(input id_t id);
    compl_i[0].valid = 1'b1;
    compl_i[0].id    = id;
    tick();
    compl_i[0] = '0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (empty_o !== 1'b1 || full_o !== 1'b0 || dispatch_ready_o !== 1'b1 ||
        commit_valid_o !== 1'b0 || count_o !== 6'd0) begin
      n_fail++;
      $display("FAIL reset: empty=%b full=%b ready=%b cvalid=%b count=%0d, want 1 0 1 0 0",
               empty_o, full_o, dispatch_ready_o, commit_valid_o, count_o);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 32; i++) begin
      disp(id_t'(i));
      n_tests++;
      if (count_o !== 6'(i + 1) || commit_valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL fill[%0d]: count=%0d cvalid=%b, want %0d 0", i, count_o, commit_valid_o, i + 1);
      end
    end
    n_tests++;
    if (full_o !== 1'b1 || dispatch_ready_o !== 1'b0 || empty_o !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full: full=%b ready=%b empty=%b, want 1 0 0", full_o, dispatch_ready_o, empty_o);
    end
    disp(8'd77);
    n_tests++;
    if (count_o !== 6'd32 || full_o !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_33rd: count=%0d full=%b, want 32 1", count_o, full_o);
    end
  endtask

  task automatic test_full_commit();
    compl1(8'd0);
    n_tests++;
    if (commit_valid_o !== 1'b1 || commit_entry_o !== mk(8'd0)) begin
      n_fail++;
      $display("FAIL full_head: cvalid=%b entry=%h, want 1 %h", commit_valid_o, commit_entry_o, mk(8'd0));
    end
    dispatch_valid_i = 1'b1;
    dispatch_entry_i = mk(8'd32);
    commit_ready_i   = 1'b1;
    #1;
    n_tests++;
    if (dispatch_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL full_ready: ready=%b, want 0", dispatch_ready_o);
    end
    tick();
    commit_ready_i = 1'b0;
    n_tests++;
    if (count_o !== 6'd31 || full_o !== 1'b0 || commit_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL full_commit: count=%0d full=%b cvalid=%b, want 31 0 0", count_o, full_o, commit_valid_o);
    end
    tick();
    dispatch_valid_i = 1'b0;
    n_tests++;
    if (count_o !== 6'd32 || full_o !== 1'b1) begin
      n_fail++;
      $display("FAIL full_redispatch: count=%0d full=%b, want 32 1", count_o, full_o);
    end
  endtask

  task automatic test_async_reset();
    rstn = 1'b0;
    #1;
    n_tests++;
    if (count_o !== 6'd0 || empty_o !== 1'b1 || full_o !== 1'b0 || dispatch_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: count=%0d empty=%b full=%b ready=%b, want 0 1 0 1",
               count_o, empty_o, full_o, dispatch_ready_o);
    end
    @(negedge clk);
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_out_of_order();
    do_reset();
    disp(8'd5);
    disp(8'd6);
    disp(8'd7);
    commit_ready_i = 1'b1;
    compl1(8'd7);
    compl1(8'd6);
    n_tests++;
    if (commit_valid_o !== 1'b0 || count_o !== 6'd3) begin
      n_fail++;
      $display("FAIL ooo_wait: cvalid=%b count=%0d, want 0 3", commit_valid_o, count_o);
    end
    compl1(8'd5);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (commit_valid_o !== 1'b1 || commit_entry_o !== mk(id_t'(5 + k))) begin
        n_fail++;
        $display("FAIL ooo_commit[%0d]: cvalid=%b id=%0d, want 1 %0d", k, commit_valid_o, commit_entry_o.id, 5 + k);
      end
      tick();
    end
    commit_ready_i = 1'b0;
    n_tests++;
    if (empty_o !== 1'b1 || count_o !== 6'd0) begin
      n_fail++;
      $display("FAIL ooo_drain: empty=%b count=%0d, want 1 0", empty_o, count_o);
    end
  endtask

  task automatic test_multi_port();
    do_reset();
    for (int i = 1; i <= 4; i++) disp(id_t'(i));
    compl_i[0] = '{id: 8'd3, valid: 1'b1};
    compl_i[1] = '{id: 8'd99, valid: 1'b1};
    compl_i[2] = '{id: 8'd3, valid: 1'b1};
    tick();
    for (int p = 0; p < NR_COMPL_PORTS; p++) compl_i[p] = '0;
    n_tests++;
    if (commit_valid_o !== 1'b0 || count_o !== 6'd4) begin
      n_fail++;
      $display("FAIL mport_state: cvalid=%b count=%0d, want 0 4", commit_valid_o, count_o);
    end
    compl_i[0] = '{id: 8'd1, valid: 1'b1};
    compl_i[1] = '{id: 8'd2, valid: 1'b1};
    tick();
    for (int p = 0; p < NR_COMPL_PORTS; p++) compl_i[p] = '0;
    commit_ready_i = 1'b1;
    tick();
    tick();
    n_tests++;
    if (commit_valid_o !== 1'b1 || commit_entry_o !== mk(8'd3)) begin
      n_fail++;
      $display("FAIL mport_id3: cvalid=%b id=%0d, want 1 3", commit_valid_o, commit_entry_o.id);
    end
    tick();
    commit_ready_i = 1'b0;
    n_tests++;
    if (commit_valid_o !== 1'b0 || count_o !== 6'd1 || commit_entry_o.id !== 8'd4) begin
      n_fail++;
      $display("FAIL mport_id4: cvalid=%b count=%0d id=%0d, want 0 1 4", commit_valid_o, count_o, commit_entry_o.id);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 10; i++) disp(id_t'(10 + i));
    compl_i[0] = '{id: 8'd10, valid: 1'b1};
    compl_i[1] = '{id: 8'd11, valid: 1'b1};
    tick();
    compl_i[1] = '0;
    flush_i          = 1'b1;
    dispatch_valid_i = 1'b1;
    dispatch_entry_i = mk(8'd50);
    compl_i[0]       = '{id: 8'd12, valid: 1'b1};
    commit_ready_i   = 1'b1;
    #1;
    n_tests++;
    if (commit_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_same_cycle: cvalid=%b, want 0", commit_valid_o);
    end
    tick();
    idle_inputs();
    #1;
    n_tests++;
    if (empty_o !== 1'b1 || count_o !== 6'd0 || commit_valid_o !== 1'b0 || full_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_after: empty=%b count=%0d cvalid=%b full=%b, want 1 0 0 0",
               empty_o, count_o, commit_valid_o, full_o);
    end
    disp(8'd60);
    compl1(8'd60);
    n_tests++;
    if (commit_valid_o !== 1'b1 || commit_entry_o !== mk(8'd60) || count_o !== 6'd1) begin
      n_fail++;
      $display("FAIL flush_redispatch: cvalid=%b id=%0d count=%0d, want 1 60 1",
               commit_valid_o, commit_entry_o.id, count_o);
    end
  endtask

  task automatic test_stream();
    int   next_disp;
    int   next_ret;
    int   cyc;
    logic pend_v;
    id_t  pend_id;
    next_disp = 0;
    next_ret  = 0;
    cyc       = 0;
    pend_v    = 1'b0;
    pend_id   = '0;
    do_reset();
    while (next_ret < 100 && cyc < 2000) begin
      idle_inputs();
      commit_ready_i = (cyc % 2 == 1);
      if (pend_v) compl_i[0] = '{id: pend_id, valid: 1'b1};
      pend_v = 1'b0;
      if (next_disp < 100 && dispatch_ready_o) begin
        dispatch_valid_i = 1'b1;
        dispatch_entry_i = mk(id_t'(next_disp));
        pend_v  = 1'b1;
        pend_id = id_t'(next_disp);
        next_disp++;
      end
      #1;
      if (commit_valid_o && commit_ready_i) begin
        n_tests++;
        if (commit_entry_o !== mk(id_t'(next_ret))) begin
          n_fail++;
          $display("FAIL stream_order: id=%0d entry=%h, want id %0d entry %h",
                   commit_entry_o.id, commit_entry_o, next_ret, mk(id_t'(next_ret)));
        end
        next_ret++;
      end
      if (count_o > 6'd32) begin
        n_tests++;
        n_fail++;
        $display("FAIL stream_count: count=%0d, want <= 32", count_o);
      end
      tick();
      cyc++;
    end
    idle_inputs();
    n_tests++;
    if (next_ret != 100 || empty_o !== 1'b1) begin
      n_fail++;
      $display("FAIL stream_done: retired=%0d empty=%b, want 100 1", next_ret, empty_o);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rstn    = 1'b0;
    idle_inputs();
    test_reset();
    test_fill();
    test_full_commit();
    test_async_reset();
    test_out_of_order();
    test_multi_port();
    test_flush();
    test_stream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order retirement buffer for the out-of-order core. It accepts renamed instructions from dispatch in program order and records completions from the NR_COMPL_PORTS completion ports (writeback plus LSU). It retires completed instructions from the head, one per cycle, toward the PRF-to-ARF copy stage. It sits between rename/dispatch (producer) and commit (consumer), and is cleared in one cycle on pipeline flush.

## Interface
- NR_ENTRIES, C::NR_ROB_ENTRIES (32): entry count; must be a power of two.
- NR_CPORTS, C::NR_COMPL_PORTS (3): number of completion ports.
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- dispatch_valid_i  in  1  dispatch offers an entry.
- dispatch_ready_o  out  1  ROB can accept; equals !full.
- dispatch_entry_i  in  C::rob_entry_t  id, pc, prd, ard, needprf2arf; the incoming `completed` field is ignored and stored as 0.
- compl_i  in  NR_CPORTS x C::completion_port_t  {id, valid} per port.
- commit_valid_o  out  1  head entry is completed and retirable.
- commit_ready_i  in  1  commit stage accepts the head.
- commit_entry_o  out  C::rob_entry_t  head entry contents, `completed` = 1.
- flush_i  in  1  squash all entries.
- full_o  out  1  count == NR_ENTRIES.
- empty_o  out  1  count == 0.
- count_o  out  $clog2(NR_ENTRIES)+1  number of valid entries.

## Operation
- Storage: NR_ENTRIES x rob_entry_t plus a per-entry valid bit.
- Pointers: head and tail, each $clog2(NR_ENTRIES)+1 bits. The MSB is the wrap bit.
  - empty: head == tail.
  - full: index bits equal and wrap bits differ.
- Dispatch fire (dispatch_valid_i & dispatch_ready_o & !flush_i):
  - write the entry at tail[index] with completed=0 and valid=1;
  - tail += 1, wrapping naturally modulo 2·NR_ENTRIES.
- Completion, per port p with compl_i[p].valid & !flush_i:
  - every valid entry whose id equals compl_i[p].id sets completed=1;
  - multiple ports hitting the same entry OR together;
  - an id matching no valid entry is ignored;
  - an already-completed entry stays completed.
- Commit:
  - commit_valid_o = !empty & valid[head] & completed[head] & !flush_i;
  - on commit_valid_o & commit_ready_i: clear valid[head] and head += 1.
- Count: count_next = count + dispatch_fire − commit_fire; both fires may occur in the same cycle.
- Flush has priority over everything in its cycle:
  - all valid and completed bits cleared, head = tail = 0, count = 0;
  - no dispatch, completion, or commit takes effect.
- No bypass paths:
  - dispatch_ready_o depends only on registered count, so a full ROB refuses dispatch even in a cycle where it commits;
  - a completion arriving in the same cycle as the dispatch of that id is lost. Dispatch guarantees this cannot occur.

## Timing
- Reset (rstn low, asynchronous):
  - head = tail = 0, count_o = 0, all valid/completed = 0;
  - empty_o = 1, full_o = 0, dispatch_ready_o = 1, commit_valid_o = 0;
  - commit_entry_o contents are don't-care (reads the array).
- Dispatch at cycle N: entry visible at cycle N+1; count_o updates at N+1.
- Completion at cycle N on the head entry: commit_valid_o = 1 at N+1. Minimum dispatch-to-commit latency is 2 cycles.
- Commit throughput: one entry per cycle when consecutive entries are completed.
- Wrap: after NR_ENTRIES dispatches the tail index returns to 0 with the wrap bit toggled; full is detected correctly.
- Reset asserted mid-operation: immediate clear, same values as above.

## Structure
- rob_entry_t, completion_port_t and id_t stay in package C.
- Add to C: typedef rob_ptr_t = logic [$clog2(NR_ROB_ENTRIES):0].
- Single module, no sub-modules. The id comparison is a flat per-entry × per-port compare loop.

## Test plan
- Reset then 32 dispatches with ids 0..31 and no completions:
  - full_o = 1 after the 32nd, dispatch_ready_o = 0, count_o = 32;
  - a 33rd dispatch_valid_i is not accepted.
- Dispatch ids 5, 6, 7; complete 7, then 6, then 5, one per cycle:
  - no commit until 5 completes;
  - then commits 5, 6, 7 on three consecutive cycles, in that order, with commit_ready_i = 1.
- Ports 0 and 2 both complete id 3 in the same cycle while port 1 completes absent id 99:
  - entry 3 completed;
  - no other state changes.
- ROB full with head completed; dispatch_valid_i = 1 and commit_ready_i = 1 in the same cycle:
  - commit fires, dispatch does not, count_o = 31;
  - the next cycle's dispatch is accepted.
- 10 entries valid, some completed; flush_i = 1 with a dispatch and completions in the same cycle:
  - next cycle empty_o = 1, count_o = 0, commit_valid_o = 0;
  - a following dispatch lands at index 0.
- Push and pop 100 entries with commit_ready_i toggling every other cycle:
  - ids are retired in order across multiple pointer wraps;
  - count_o never exceeds 32.
